seq_arrmul: RTL and testbench



---
 rtl/seq_arrmul_pkg.sv | 18 +
 rtl/seq_arrmul_if.sv | 23 ++
 rtl/seq_arrmul_row.sv | 23 ++
 rtl/seq_arrmul.sv | 101 ++++++++++
 tb/tb_seq_arrmul.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_arrmul_pkg.sv
// Shared types and helpers for the row-serial array multiplier.
package arrmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the row counter: ceil(log2(n)), never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/seq_arrmul_if.sv
// Operand/product handshake bundle for seq_arrmul.
interface seq_arrmul_if #(parameter int N = 8);

    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_a;
    logic [N-1:0]   in_b;
    logic           in_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_p;

    modport master (
        output in_valid, in_a, in_b, in_signed, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, out_ready,
        output in_ready, out_valid, out_p
    );

endinterface

// File: rtl/seq_arrmul_row.sv
// One partial-product row: gate, shift and add/sub into the 2N-bit accumulator.
import arrmul_pkg::*;

module seq_arrmul_row #(
    parameter int N  = 8,
    parameter int CW = clog2_min1(N)
) (
    input  logic [2*N-1:0] acc,
    input  logic [2*N-1:0] a_ext,
    input  logic           b_bit,
    input  logic [CW-1:0]  idx,
    input  logic           sub,
    output logic [2*N-1:0] acc_next
);

    logic [2*N-1:0] pp;

    always_comb begin
        pp       = b_bit ? (a_ext << idx) : '0;
        acc_next = sub ? (acc - pp) : (acc + pp);
    end

endmodule

// File: rtl/seq_arrmul.sv
// Row-serial signed/unsigned multiplier: one partial-product row per clock.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | accumulating row cnt of N rows
// DONE  | product held on out_p until out_ready
import arrmul_pkg::*;

module seq_arrmul #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    seq_arrmul_if.slave  bus,
    output logic         busy
);

    localparam int            CW   = clog2_min1(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         state;
    logic [2*N-1:0] a_ext;
    logic [N-1:0]   b_reg;
    logic           sgn;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] acc_next;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [2*N-1:0] out_p_r;

    // The last row carries negative weight in two's-complement mode.
    seq_arrmul_row #(.N(N), .CW(CW)) u_row (
        .acc      (acc),
        .a_ext    (a_ext),
        .b_bit    (b_reg[cnt]),
        .idx      (cnt),
        .sub      (sgn && (cnt == LAST)),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_ext       <= '0;
            b_reg       <= '0;
            sgn         <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_p_r     <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        a_ext      <= bus.in_signed ? {{N{bus.in_a[N-1]}}, bus.in_a}
                                                    : {{N{1'b0}}, bus.in_a};
                        b_reg      <= bus.in_b;
                        sgn        <= bus.in_signed;
                        acc        <= '0;
                        cnt        <= '0;
                        in_ready_r <= 1'b0;
                        busy       <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    if (cnt == LAST) begin
                        out_p_r     <= acc_next;
                        out_valid_r <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_p     = out_p_r;

endmodule

// File: tb/tb_seq_arrmul.sv
// Directed and table-driven bench for seq_arrmul at N=4, plus N=1 and N=8 builds.
module tb_seq_arrmul;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_arrmul_if #(.N(4)) ifc ();
    seq_arrmul_if #(.N(1)) if1 ();
    seq_arrmul_if #(.N(8)) if8 ();
    logic busy, busy1, busy8;

    seq_arrmul #(.N(4)) dut  (.clk(clk), .rst(rst), .bus(ifc), .busy(busy));
    seq_arrmul #(.N(1)) dut1 (.clk(clk), .rst(rst), .bus(if1), .busy(busy1));
    seq_arrmul #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(if8), .busy(busy8));

    int tests = 0;
    int fails = 0;
    int n_acc = 0;
    int n_out = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       s;
        logic [7:0] p;
    } vec_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       s;
    } op_t;

    vec_t vecs[10];

    always @(posedge clk) begin
        if (!rst) begin
            if (ifc.in_valid && ifc.in_ready) n_acc++;
            if (ifc.out_valid && ifc.out_ready) n_out++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference product from integer arithmetic on the n-bit operands.
    function automatic logic [15:0] refm(input int n, input logic [7:0] a,
                                         input logic [7:0] b, input logic s);
        longint va, vb, pr;
        va = longint'(a);
        vb = longint'(b);
        if (s && a[n-1]) va -= (longint'(1) << n);
        if (s && b[n-1]) vb -= (longint'(1) << n);
        pr = va * vb;
        return 16'(pr & ((longint'(1) << (2 * n)) - 1));
    endfunction

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input int gi, input int go,
                        output logic [7:0] p, output int lat, output bit ir_bad);
        int g;
        ir_bad = 1'b0;
        repeat (gi) begin @(posedge clk); #1; end
        g = 0;
        while (!ifc.in_ready && g < 50) begin @(posedge clk); #1; g++; end
        ifc.in_a = a; ifc.in_b = b; ifc.in_signed = s; ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        lat = 0;
        while (!ifc.out_valid && lat < 50) begin
            if (ifc.in_ready) ir_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        repeat (go) begin
            if (ifc.in_ready || !ifc.out_valid) ir_bad = 1'b1;
            @(posedge clk); #1;
        end
        if (ifc.in_ready) ir_bad = 1'b1;
        p = ifc.out_p;
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
    endtask

    task automatic run1(input logic a, input logic b, input logic s,
                        output logic [1:0] p, output int lat);
        if1.in_a = a; if1.in_b = b; if1.in_signed = s; if1.in_valid = 1'b1;
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        lat = 0;
        while (!if1.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        p = if1.out_p;
        if1.out_ready = 1'b1;
        @(posedge clk); #1;
        if1.out_ready = 1'b0;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [15:0] p, output int lat);
        if8.in_a = a; if8.in_b = b; if8.in_signed = s; if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        lat = 0;
        while (!if8.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        p = if8.out_p;
        if8.out_ready = 1'b1;
        @(posedge clk); #1;
        if8.out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0]  p;
        logic [1:0]  p1;
        logic [15:0] p8;
        logic [7:0]  a8, b8;
        logic        s8;
        int          lat, g, last;
        bit          bad, seen;
        op_t         q[$];
        op_t         o;

        ifc.in_valid = 0; ifc.in_a = 0; ifc.in_b = 0; ifc.in_signed = 0; ifc.out_ready = 0;
        if1.in_valid = 0; if1.in_a = 0; if1.in_b = 0; if1.in_signed = 0; if1.out_ready = 0;
        if8.in_valid = 0; if8.in_a = 0; if8.in_b = 0; if8.in_signed = 0; if8.out_ready = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", ifc.in_ready, 1);
        chk("reset_out_valid", ifc.out_valid, 0);
        chk("reset_out_p", ifc.out_p, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;

        vecs[0] = '{4'hF, 4'hF, 1'b0, 8'hE1};
        vecs[1] = '{4'h8, 4'h8, 1'b1, 8'h40};
        vecs[2] = '{4'h8, 4'h7, 1'b1, 8'hC8};
        vecs[3] = '{4'h8, 4'h7, 1'b0, 8'h38};
        vecs[4] = '{4'h3, 4'h5, 1'b0, 8'h0F};
        vecs[5] = '{4'hF, 4'hF, 1'b1, 8'h01};
        vecs[6] = '{4'hF, 4'h1, 1'b1, 8'hFF};
        vecs[7] = '{4'h7, 4'h7, 1'b1, 8'h31};
        vecs[8] = '{4'h0, 4'h9, 1'b1, 8'h00};
        vecs[9] = '{4'h9, 4'h0, 1'b0, 8'h00};

        for (int i = 0; i < 10; i++) begin
            run4(vecs[i].a, vecs[i].b, vecs[i].s, 0, 0, p, lat, bad);
            chk("vec_p", p, vecs[i].p);
            chk("vec_latency", lat, 4);
            chk("vec_in_ready_low", bad, 0);
            chk("vec_post_in_ready", ifc.in_ready, 1);
            chk("vec_post_out_valid", ifc.out_valid, 0);
            chk("vec_post_busy", busy, 0);
        end

        // Backpressure: product must hold while out_ready stays low.
        ifc.in_a = 4'd3; ifc.in_b = 4'd5; ifc.in_signed = 1'b0; ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        chk("bp_busy", busy, 1);
        g = 0;
        while (!ifc.out_valid && g < 50) begin @(posedge clk); #1; g++; end
        for (int i = 0; i < 6; i++) begin
            chk("bp_out_p", ifc.out_p, 8'h0F);
            chk("bp_out_valid", ifc.out_valid, 1);
            chk("bp_in_ready", ifc.in_ready, 0);
            @(posedge clk); #1;
        end
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
        chk("bp_release_out_valid", ifc.out_valid, 0);
        chk("bp_release_in_ready", ifc.in_ready, 1);
        chk("bp_hold_out_p", ifc.out_p, 8'h0F);

        // Reset during the second BUSY cycle discards the operation.
        ifc.in_a = 4'hF; ifc.in_b = 4'hF; ifc.in_signed = 1'b0; ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_in_ready", ifc.in_ready, 1);
        chk("rst_mid_out_valid", ifc.out_valid, 0);
        chk("rst_mid_out_p", ifc.out_p, 0);
        chk("rst_mid_busy", busy, 0);
        seen = 1'b0;
        ifc.out_ready = 1'b1;
        repeat (10) begin @(posedge clk); #1; if (ifc.out_valid) seen = 1'b1; end
        ifc.out_ready = 1'b0;
        chk("rst_mid_no_product", seen, 0);

        // Continuous in_valid with operands changing every cycle.
        ifc.out_ready = 1'b1;
        last = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc < 40) begin
                ifc.in_valid  = 1'b1;
                ifc.in_a      = 4'(cyc * 3);
                ifc.in_b      = 4'(cyc * 5 + 1);
                ifc.in_signed = cyc[0];
            end else begin
                ifc.in_valid = 1'b0;
            end
            if (ifc.in_valid && ifc.in_ready) begin
                q.push_back('{ifc.in_a, ifc.in_b, ifc.in_signed});
                if (last >= 0) chk("iso_interval", cyc - last, 6);
                last = cyc;
            end
            if (ifc.out_valid) begin
                if (q.size() == 0) begin
                    chk("iso_spurious_out_valid", 1, 0);
                end else begin
                    o = q.pop_front();
                    chk("iso_p", ifc.out_p, refm(4, {4'h0, o.a}, {4'h0, o.b}, o.s));
                end
            end
            @(posedge clk); #1;
        end
        ifc.out_ready = 1'b0;
        chk("iso_drained", q.size(), 0);

        // Exhaustive N=4, both modes, with random gaps on both sides.
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    run4(4'(a), 4'(b), 1'(s), int'($urandom_range(0, 2)),
                         int'($urandom_range(0, 2)), p, lat, bad);
                    chk("exh_p", p, refm(4, 8'(a), 8'(b), 1'(s)));
                end

        // N=1 boundary build.
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 2; a++)
                for (int b = 0; b < 2; b++) begin
                    run1(1'(a), 1'(b), 1'(s), p1, lat);
                    chk("n1_p", p1, refm(1, 8'(a), 8'(b), 1'(s)));
                    chk("n1_latency", lat, 1);
                end

        // N=8 build: corners plus random operands.
        for (int i = 0; i < 40; i++) begin
            case (i)
                0:       begin a8 = 8'h80; b8 = 8'h80; s8 = 1'b1; end
                1:       begin a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b0; end
                2:       begin a8 = 8'h80; b8 = 8'h7F; s8 = 1'b1; end
                default: begin a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom); end
            endcase
            run8(a8, b8, s8, p8, lat);
            chk("n8_p", p8, refm(8, a8, b8, s8));
            chk("n8_latency", lat, 8);
        end

        chk("accepts_vs_products", n_out, n_acc - 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
